uart_tx_lcr: RTL and testbench
==============================

Name: uart_tx_lcr

Overview:
- Parametrised successor transmitter for the UART 16550 datapath.
- Adds a runtime divisor with 16x bit timing, 16550-style line control (5-8 data bits, none/even/odd/stick parity, 1 or 2 stop bits) and a TX holding FIFO.
- Sits between the register-file write path and the serial pad; back-to-back frames go out with no idle gap.

Parameters:
- FIFO_DEPTH, 16, TX FIFO entries; power of two, at least 2.
- DIV_W, 16, width of the baud divisor.
- OVERSAMPLE, 16, clk-divisor ticks per bit; the bit period is OVERSAMPLE*divisor clk cycles.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- divisor  in  DIV_W  baud divisor; 0 halts the transmitter
- wls  in  2  word length: 0=5, 1=6, 2=7, 3=8 bits
- stb  in  1  0=1 stop bit, 1=2 stop bits
- pen  in  1  parity enable
- eps  in  1  even parity select
- sp  in  1  stick parity
- wr_en  in  1  push wr_data into FIFO
- wr_data  in  8  byte; bits above the word length are ignored
- fifo_full  out  1  FIFO full
- fifo_empty  out  1  FIFO empty
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
- overrun  out  1  1-cycle pulse on a rejected write
- tx  out  1  serial line, idle high
- busy  out  1  a frame is in progress
- tx_done  out  1  1-cycle pulse at end of each frame's last stop bit

Behaviour:
- Reset (async):
  - tx=1, busy=0, tx_done=0, overrun=0.
  - FIFO cleared: count=0, fifo_empty=1, fifo_full=0.
  - FSM returns to IDLE; applies mid-frame, and tx rises immediately.
- FIFO:
  - A write is accepted when wr_en=1 and fifo_full=0 (registered flag).
  - wr_en=1 while full: data dropped, overrun pulses next cycle, count unchanged.
  - A push and a pop in the same cycle leave count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Leaves when fifo_empty=0 and divisor!=0: pops the head entry and latches data, wls, stb, pen, eps, sp and divisor into a frame context.
  - On that same edge, tx<=0, busy<=1, state=START. Latency: 1 clk after the first write into an empty FIFO.
- Bit timer:
  - Counts clk from 0 to OVERSAMPLE*divisor_latched-1 and restarts at each bit boundary.
  - Config changes mid-frame take effect on the next frame only.
- START: one bit period of tx=0, then DATA.
- DATA: LSB first; 5+wls bits, each one bit period.
- PARITY (entered only when pen=1):
  - sp=0, eps=1: parity bit = XOR of the data bits.
  - sp=0, eps=0: parity bit = XNOR of the data bits.
  - sp=1: parity bit = ~eps.
- STOP:
  - tx=1 for one bit period (stb=0) or two bit periods (stb=1).
  - At the final stop-bit boundary, tx_done pulses.
  - If fifo_empty=0 and divisor!=0: immediate pop, tx<=0, START (no idle gap).
  - Otherwise: IDLE, busy<=0.
- divisor=0 while in IDLE: no pop; FIFO contents are held.

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- Defined: adds input port brk (1 bit).
  - While brk=1, tx is forced 0 combinationally after the tx register.
  - FSM, timer and FIFO keep running unchanged.
  - Releasing brk restores the registered tx value in the same cycle.
- Undefined: no brk port; tx is driven only by the FSM.

Test Plan:
1. Reset; divisor=1, wls=3, pen=0, stb=0; write 0x55 -> tx low 1 clk after the write; tx per 16-clk bit = 0,1,0,1,0,1,0,1,0,1; tx_done at clk 160 after tx falls; busy=0 afterwards.
2. wls=2, pen=1, eps=1, stb=1, divisor=2; write 0x41 -> data 1,0,0,0,0,0,1, parity 0, two stop bits; frame 11 bits = 352 clks. Repeat with eps=0 -> parity 1; with sp=1, eps=1 -> parity 0.
3. divisor=4, 8N1; write 17 bytes 0x00..0x10 in consecutive cycles before the first pop completes -> 16 accepted, overrun on the 17th, fifo_full=1 then falls; 16 frames with no tx-high gap between the stop bit and the next start bit; 16 tx_done pulses.
4. Assert rst mid-DATA of the second queued frame -> tx=1 and count=0 immediately; no further frames; tx_done never pulses for the aborted frame.
5. divisor=0; write 0xA5 -> tx stays 1, fifo_count=1. Set divisor=1 -> frame starts next clk.
6. With UART_TX_BREAK_EN: brk=1 during a frame -> tx=0 throughout; tx_done still pulses at the normal frame end.

Source files
------------

// File: rtl/uart_tx_lcr.sv
// ============================================================================
// Module   : uart_tx_lcr
// Brief    : 16550-style UART transmitter with runtime divisor, line control
//            (5-8 bits, none/even/odd/stick parity, 1-2 stops) and TX FIFO.
//            Optional `UART_TX_BREAK_EN adds a brk input forcing tx low.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_tx_lcr #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16,
    parameter int OVERSAMPLE = 16
) (
    input  logic                          clk,
    input  logic                          rst,
`ifdef UART_TX_BREAK_EN
    input  logic                          brk,
`endif
    input  logic [DIV_W-1:0]              divisor,
    input  logic [1:0]                    wls,
    input  logic                          stb,
    input  logic                          pen,
    input  logic                          eps,
    input  logic                          sp,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    output logic                          tx,
    output logic                          busy,
    output logic                          tx_done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = DIV_W + $clog2(OVERSAMPLE) + 1;
    localparam logic [AW:0] C_DEPTH = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // TX holding FIFO
    // ------------------------------------------------------------------------
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overrun;
    logic          w_push;
    logic          w_pop;
    logic [7:0]    w_head;

    assign fifo_full  = (r_count == C_DEPTH);
    assign fifo_empty = (r_count == '0);
    assign fifo_count = r_count;
    assign overrun    = r_overrun;
    assign w_push     = wr_en & ~fifo_full;
    assign w_head     = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_overrun <= wr_en & fifo_full;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
    end

    // ------------------------------------------------------------------------
    // Frame context, captured when a byte is popped
    // ------------------------------------------------------------------------
    logic [7:0]    w_mask;
    logic [7:0]    w_masked;
    logic          w_par;
    logic [TW-1:0] w_bit_len;
    logic          w_can_start;

    always_comb begin
        case (wls)
            2'd0:    w_mask = 8'h1F;
            2'd1:    w_mask = 8'h3F;
            2'd2:    w_mask = 8'h7F;
            default: w_mask = 8'hFF;
        endcase
    end

    assign w_masked    = w_head & w_mask;
    assign w_par       = sp ? ~eps : (eps ? ^w_masked : ~^w_masked);
    assign w_bit_len   = TW'(OVERSAMPLE) * TW'(divisor);
    assign w_can_start = ~fifo_empty & (divisor != '0);

    logic [7:0]    r_data;
    logic [2:0]    r_last_idx;
    logic          r_stb;
    logic          r_pen;
    logic          r_par;
    logic [TW-1:0] r_bit_len_m1;

    // ------------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------------
    state_t        r_state;
    state_t        w_state_n;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_n;
    logic [2:0]    r_bit_idx;
    logic [2:0]    w_bit_idx_n;
    logic [2:0]    w_idx_inc;
    logic          r_stop_idx;
    logic          w_stop_idx_n;
    logic          r_tx;
    logic          w_tx_n;
    logic          r_busy;
    logic          w_busy_n;
    logic          r_done;
    logic          w_done_n;
    logic          w_load;
    logic          w_bit_end;

    assign w_bit_end = (r_timer == r_bit_len_m1);
    assign w_idx_inc = r_bit_idx + 3'd1;
    assign w_pop     = w_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_timer    <= w_timer_n;
            r_bit_idx  <= w_bit_idx_n;
            r_stop_idx <= w_stop_idx_n;
            r_tx       <= w_tx_n;
            r_busy     <= w_busy_n;
            r_done     <= w_done_n;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_timer_n    = w_bit_end ? '0 : r_timer + 1'b1;
        w_bit_idx_n  = r_bit_idx;
        w_stop_idx_n = r_stop_idx;
        w_tx_n       = r_tx;
        w_busy_n     = r_busy;
        w_done_n     = 1'b0;
        w_load       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_timer_n = '0;
                w_tx_n    = 1'b1;
                w_busy_n  = 1'b0;
                if (w_can_start) begin
                    w_load    = 1'b1;
                    w_tx_n    = 1'b0;
                    w_busy_n  = 1'b1;
                    w_state_n = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_n   = S_DATA;
                    w_bit_idx_n = 3'd0;
                    w_tx_n      = r_data[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == r_last_idx) begin
                        w_stop_idx_n = 1'b0;
                        if (r_pen) begin
                            w_state_n = S_PARITY;
                            w_tx_n    = r_par;
                        end else begin
                            w_state_n = S_STOP;
                            w_tx_n    = 1'b1;
                        end
                    end else begin
                        w_bit_idx_n = w_idx_inc;
                        w_tx_n      = r_data[w_idx_inc];
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_n    = S_STOP;
                    w_stop_idx_n = 1'b0;
                    w_tx_n       = 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_stb && !r_stop_idx) begin
                        w_stop_idx_n = 1'b1;
                    end else begin
                        w_done_n = 1'b1;
                        // Chain straight into the next start bit when data waits
                        if (w_can_start) begin
                            w_load    = 1'b1;
                            w_tx_n    = 1'b0;
                            w_state_n = S_START;
                        end else begin
                            w_tx_n    = 1'b1;
                            w_busy_n  = 1'b0;
                            w_state_n = S_IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_tx_n    = 1'b1;
                w_busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data       <= '0;
            r_last_idx   <= 3'd7;
            r_stb        <= 1'b0;
            r_pen        <= 1'b0;
            r_par        <= 1'b0;
            r_bit_len_m1 <= '0;
        end else if (w_load) begin
            r_data       <= w_masked;
            r_last_idx   <= 3'd4 + {1'b0, wls};
            r_stb        <= stb;
            r_pen        <= pen;
            r_par        <= w_par;
            r_bit_len_m1 <= w_bit_len - TW'(1);
        end
    end

    assign busy    = r_busy;
    assign tx_done = r_done;

`ifdef UART_TX_BREAK_EN
    assign tx = r_tx & ~brk;
`else
    assign tx = r_tx;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_lcr.sv
// ============================================================================
// Module   : tb_uart_tx_lcr
// Brief    : Self-checking bench for uart_tx_lcr; frames decoded from tx and
//            compared against a scoreboard of model frames.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_lcr;

    localparam int FIFO_DEPTH = 16;
    localparam int DIV_W      = 16;
    localparam int OVERSAMPLE = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [DIV_W-1:0] divisor = '0;
    logic [1:0]       wls = 2'd3;
    logic             stb = 1'b0;
    logic             pen = 1'b0;
    logic             eps = 1'b0;
    logic             sp = 1'b0;
    logic             wr_en = 1'b0;
    logic [7:0]       wr_data = 8'h00;
    logic             fifo_full;
    logic             fifo_empty;
    logic [4:0]       fifo_count;
    logic             overrun;
    logic             tx;
    logic             busy;
    logic             tx_done;
`ifdef UART_TX_BREAK_EN
    logic             brk = 1'b0;
`endif

    always #5 clk = ~clk;

    uart_tx_lcr #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DIV_W      (DIV_W),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef UART_TX_BREAK_EN
        .brk        (brk),
`endif
        .divisor    (divisor),
        .wls        (wls),
        .stb        (stb),
        .pen        (pen),
        .eps        (eps),
        .sp         (sp),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fifo_count (fifo_count),
        .overrun    (overrun),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    typedef struct {
        logic [11:0] bits;
        int          len;
    } frame_t;

    frame_t exp_q[$];
    int     n_tests = 0;
    int     n_fail  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line bits in transmission order: start, data LSB first, parity, stops
    function automatic frame_t model_frame(input logic [7:0] d, input int nb, input bit pe,
                                           input bit ep, input bit stk, input int nstop);
        frame_t f;
        int     k;
        bit     ones;
        f.bits = '0;
        ones   = 1'b0;
        k      = 1;
        for (int i = 0; i < nb; i++) begin
            f.bits[k] = d[i];
            ones      = ones ^ d[i];
            k++;
        end
        if (pe) begin
            f.bits[k] = stk ? !ep : (ep ? ones : !ones);
            k++;
        end
        for (int s = 0; s < nstop; s++) begin
            f.bits[k] = 1'b1;
            k++;
        end
        f.len = k;
        return f;
    endfunction

    task automatic set_cfg(input int div, input int w, input bit p, input bit e,
                           input bit s, input bit st);
        divisor = DIV_W'(div);
        wls     = 2'(w);
        pen     = p;
        eps     = e;
        sp      = s;
        stb     = st;
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        exp_q.push_back(model_frame(d, 5 + int'(wls), pen, eps, sp, stb ? 2 : 1));
        tick();
        wr_en   = 1'b0;
    endtask

    // Captures one frame from tx; returns at the sample after its last stop boundary
    task automatic rx_frame(input int bl, input int len, output logic [11:0] bits,
                            output bit started, output bit gap, output int done_cnt,
                            output bit done_end, output bit saw_high);
        bits     = '0;
        started  = 1'b0;
        gap      = 1'b0;
        done_cnt = 0;
        done_end = 1'b0;
        saw_high = 1'b0;
        if (tx !== 1'b0) begin
            gap = 1'b1;
            for (int i = 0; i < 4000 && tx !== 1'b0; i++) tick();
        end
        if (tx !== 1'b0) return;
        started = 1'b1;
        for (int c = 1; c <= len * bl; c++) begin
            tick();
            if (tx === 1'b1) saw_high = 1'b1;
            if (c % bl == bl / 2) bits[c / bl] = tx;
            if (tx_done === 1'b1) done_cnt++;
            if (c == len * bl) done_end = tx_done;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_tests++; if (tx !== 1'b1)         begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_tests++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (tx_done !== 1'b0)    begin n_fail++; $display("FAIL reset_done: got %b want 0", tx_done); end
        n_tests++; if (overrun !== 1'b0)    begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        n_tests++; if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        n_tests++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", fifo_empty); end
        n_tests++; if (fifo_full !== 1'b0)  begin n_fail++; $display("FAIL reset_full: got %b want 0", fifo_full); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_8n1();
        frame_t      e;
        logic [11:0] bits;
        bit          st, gp, de, sh;
        int          dc;
        set_cfg(1, 3, 0, 0, 0, 0);
        write_byte(8'h55);
        n_tests++; if (tx !== 1'b1) begin n_fail++; $display("FAIL basic_pre_start: got %b want 1", tx); end
        tick();
        n_tests++; if (tx !== 1'b0)   begin n_fail++; $display("FAIL basic_latency: got %b want 0", tx); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
        e = exp_q.pop_front();
        rx_frame(16, e.len, bits, st, gp, dc, de, sh);
        n_tests++; if (bits !== 12'h2AA) begin n_fail++; $display("FAIL basic_bits: got %h want 2aa", bits); end
        n_tests++; if (bits !== e.bits)  begin n_fail++; $display("FAIL basic_model: got %h want %h", bits, e.bits); end
        n_tests++; if (de !== 1'b1 || dc != 1) begin n_fail++; $display("FAIL basic_done: end=%b cnt=%0d want 1/1", de, dc); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_parity();
        bit          e_tab [3] = '{1'b1, 1'b0, 1'b1};
        bit          s_tab [3] = '{1'b0, 1'b0, 1'b1};
        bit          p_tab [3] = '{1'b0, 1'b1, 1'b0};
        frame_t      e;
        logic [11:0] bits;
        bit          st, gp, de, sh;
        int          dc;
        for (int k = 0; k < 3; k++) begin
            set_cfg(2, 2, 1, e_tab[k], s_tab[k], 1);
            write_byte(8'h41);
            tick();
            e = exp_q.pop_front();
            rx_frame(32, e.len, bits, st, gp, dc, de, sh);
            n_tests++; if (bits !== e.bits) begin n_fail++; $display("FAIL parity_frame%0d: got %h want %h", k, bits, e.bits); end
            n_tests++; if (bits[8] !== p_tab[k]) begin n_fail++; $display("FAIL parity_bit%0d: got %b want %b", k, bits[8], p_tab[k]); end
            n_tests++; if (de !== 1'b1 || dc != 1) begin n_fail++; $display("FAIL parity_done%0d: end=%b cnt=%0d want 1/1", k, de, dc); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        frame_t      e;
        logic [11:0] bits;
        bit          st, gp, de, sh;
        int          dc;
        int          done_total = 0;
        set_cfg(0, 3, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) write_byte(8'(i));
        n_tests++; if (fifo_full !== 1'b1 || overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_full: full=%b ovr=%b want 1/0", fifo_full, overrun); end
        wr_en   = 1'b1;
        wr_data = 8'h10;
        tick();
        wr_en   = 1'b0;
        n_tests++; if (overrun !== 1'b1)     begin n_fail++; $display("FAIL b2b_overrun: got %b want 1", overrun); end
        n_tests++; if (fifo_count !== 5'd16) begin n_fail++; $display("FAIL b2b_count: got %0d want 16", fifo_count); end
        tick();
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun_pulse: got %b want 0", overrun); end
        divisor = 16'd4;
        tick();
        n_tests++; if (tx !== 1'b0 || fifo_full !== 1'b0 || fifo_count !== 5'd15)
            begin n_fail++; $display("FAIL b2b_first_pop: tx=%b full=%b cnt=%0d want 0/0/15", tx, fifo_full, fifo_count); end
        for (int f = 0; f < 16; f++) begin
            e = exp_q.pop_front();
            rx_frame(64, e.len, bits, st, gp, dc, de, sh);
            done_total += dc;
            n_tests++; if (bits !== e.bits) begin n_fail++; $display("FAIL b2b_frame%0d: got %h want %h", f, bits, e.bits); end
            if (f > 0) begin
                n_tests++; if (gp !== 1'b0) begin n_fail++; $display("FAIL b2b_gap%0d: got %b want 0", f, gp); end
            end
        end
        n_tests++; if (done_total != 16) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 16", done_total); end
        n_tests++; if (busy !== 1'b0 || tx !== 1'b1) begin n_fail++; $display("FAIL b2b_end: busy=%b tx=%b want 0/1", busy, tx); end
    endtask

    task automatic test_reset_mid_frame();
        frame_t      e;
        logic [11:0] bits;
        bit          st, gp, de, sh;
        int          dc;
        int          lows = 0;
        int          dones = 0;
        set_cfg(1, 3, 0, 0, 0, 0);
        write_byte(8'hFF);
        write_byte(8'h00);
        write_byte(8'h33);
        tick();
        e = exp_q.pop_front();
        rx_frame(16, e.len, bits, st, gp, dc, de, sh);
        n_tests++; if (bits !== e.bits) begin n_fail++; $display("FAIL rstmid_frame1: got %h want %h", bits, e.bits); end
        for (int i = 0; i < 40; i++) tick();
        n_tests++; if (tx !== 1'b0 || fifo_count !== 5'd1) begin n_fail++; $display("FAIL rstmid_pre: tx=%b cnt=%0d want 0/1", tx, fifo_count); end
        #2 rst = 1'b1;
        #1;
        n_tests++; if (tx !== 1'b1 || fifo_count !== 5'd0 || busy !== 1'b0)
            begin n_fail++; $display("FAIL rstmid_async: tx=%b cnt=%0d busy=%b want 1/0/0", tx, fifo_count, busy); end
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 400; i++) begin
            tick();
            if (tx !== 1'b1) lows++;
            if (tx_done !== 1'b0) dones++;
        end
        n_tests++; if (lows != 0 || dones != 0) begin n_fail++; $display("FAIL rstmid_quiet: lows=%0d dones=%0d want 0/0", lows, dones); end
    endtask

    task automatic test_div_zero();
        frame_t      e;
        logic [11:0] bits;
        bit          st, gp, de, sh;
        int          dc;
        int          lows = 0;
        set_cfg(0, 3, 0, 0, 0, 0);
        write_byte(8'hA5);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx !== 1'b1) lows++;
        end
        n_tests++; if (lows != 0 || fifo_count !== 5'd1) begin n_fail++; $display("FAIL div0_hold: lows=%0d cnt=%0d want 0/1", lows, fifo_count); end
        divisor = 16'd1;
        tick();
        n_tests++; if (tx !== 1'b0) begin n_fail++; $display("FAIL div0_start: got %b want 0", tx); end
        e = exp_q.pop_front();
        rx_frame(16, e.len, bits, st, gp, dc, de, sh);
        n_tests++; if (bits !== e.bits || de !== 1'b1) begin n_fail++; $display("FAIL div0_frame: got %h/%b want %h/1", bits, de, e.bits); end
    endtask

`ifdef UART_TX_BREAK_EN
    task automatic test_break();
        frame_t      e;
        logic [11:0] bits;
        bit          st, gp, de, sh;
        int          dc;
        set_cfg(1, 3, 0, 0, 0, 0);
        brk = 1'b1;
        write_byte(8'hFF);
        tick();
        e = exp_q.pop_front();
        rx_frame(16, e.len, bits, st, gp, dc, de, sh);
        n_tests++; if (sh !== 1'b0) begin n_fail++; $display("FAIL brk_low: saw_high=%b want 0", sh); end
        n_tests++; if (de !== 1'b1 || dc != 1) begin n_fail++; $display("FAIL brk_done: end=%b cnt=%0d want 1/1", de, dc); end
        brk = 1'b0;
        #1;
        n_tests++; if (tx !== 1'b1) begin n_fail++; $display("FAIL brk_release: got %b want 1", tx); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic_8n1();
        test_parity();
        test_back_to_back();
        test_reset_mid_frame();
        test_div_zero();
`ifdef UART_TX_BREAK_EN
        test_break();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

endmodule

`default_nettype wire
